// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on a valid/ready data bus,
// formats load data, flags misalignment and bus errors, and registers mem_wb.
module mem_stage #(
    parameter int XLEN          = 32,
    parameter int PC_WIDTH      = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [PC_WIDTH-1:0]      ex_mem_pc_i,
    input  logic [INSTR_WIDTH-1:0]   ex_mem_instr_i,
    input  logic [XLEN-1:0]          ex_mem_rs2_rdata_i,
    input  logic [XLEN-1:0]          ex_mem_alu_res_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_mem_ex_rd_idx_i,
    input  logic                     ex_mem_ex_rd_en_i,
    input  logic [XLEN-1:0]          ex_mem_ex_rd_wdata_i,
    input  logic                     ex_mem_if_excp_misalign_i,
    input  logic                     ex_mem_if_bus_err_i,
    input  logic                     ex_mem_id_excp_ilegl_instr_i,
    input  logic                     ex_mem_id_excp_ecall_i,
    input  logic                     ex_mem_id_excp_ebreak_i,
    input  logic                     ex_mem_id_excp_mret_i,
    input  logic                     flush_i,

    output logic                     dbus_req_valid_o,
    input  logic                     dbus_req_ready_i,
    output logic [XLEN-1:0]          dbus_req_addr_o,
    output logic                     dbus_req_we_o,
    output logic [XLEN-1:0]          dbus_req_wdata_o,
    output logic [3:0]               dbus_req_wstrb_o,
    input  logic                     dbus_rsp_valid_i,
    input  logic [XLEN-1:0]          dbus_rsp_rdata_i,
    input  logic                     dbus_rsp_err_i,

    output logic                     mem_stall_o,

    output logic [PC_WIDTH-1:0]      mem_wb_pc_o,
    output logic [INSTR_WIDTH-1:0]   mem_wb_instr_o,
    output logic [REG_IDX_WIDTH-1:0] mem_wb_rd_idx_o,
    output logic                     mem_wb_rd_en_o,
    output logic [XLEN-1:0]          mem_wb_rd_wdata_o,
    output logic                     mem_wb_if_excp_misalign_o,
    output logic                     mem_wb_if_bus_err_o,
    output logic                     mem_wb_id_excp_ilegl_instr_o,
    output logic                     mem_wb_id_excp_ecall_o,
    output logic                     mem_wb_id_excp_ebreak_o,
    output logic                     mem_wb_id_excp_mret_o,
    output logic                     mem_wb_excp_ld_misalign_o,
    output logic                     mem_wb_excp_st_misalign_o,
    output logic                     mem_wb_excp_ld_bus_err_o,
    output logic                     mem_wb_excp_st_bus_err_o,
    output logic [XLEN-1:0]          mem_wb_excp_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    function automatic logic [XLEN-1:0] f_load_fmt(input logic [2:0] f3,
                                                   input logic [1:0] lane,
                                                   input logic [XLEN-1:0] word);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [XLEN-1:0]    res;
        sb = word[{lane, 3'b000} +: 8];
        sh = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{(XLEN-8){sb[7]}}, sb};
            3'b001:  res = {{(XLEN-16){sh[15]}}, sh};
            3'b100:  res = {{(XLEN-8){1'b0}}, sb};
            3'b101:  res = {{(XLEN-16){1'b0}}, sh};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] f_st_wstrb(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] res;
        case (f3)
            3'b000:  res = 4'b0001 << lane;
            3'b001:  res = 4'b0011 << lane;
            3'b010:  res = 4'b1111;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    function automatic logic [XLEN-1:0] f_st_wdata(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
        logic [XLEN-1:0] res;
        case (f3)
            3'b000:  res = {4{rs2[7:0]}};
            3'b001:  res = {2{rs2[15:0]}};
            default: res = rs2;
        endcase
        return res;
    endfunction

    // ---- decode of the instruction presented by ex_mem ----
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_addr;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_misal;
    logic            w_up_excp;
    logic            w_ld_mis;
    logic            w_st_mis;
    logic            w_need_bus;
    logic            w_launch;

    assign w_opcode   = ex_mem_instr_i[6:0];
    assign w_f3       = ex_mem_instr_i[14:12];
    assign w_addr     = ex_mem_alu_res_i;
    assign w_is_load  = (w_opcode == OP_LOAD) &&
                        (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010 ||
                         w_f3 == 3'b100 || w_f3 == 3'b101);
    assign w_is_store = (w_opcode == OP_STORE) &&
                        (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010);
    assign w_misal    = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                        ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_up_excp  = ex_mem_if_excp_misalign_i | ex_mem_if_bus_err_i |
                        ex_mem_id_excp_ilegl_instr_i | ex_mem_id_excp_ecall_i |
                        ex_mem_id_excp_ebreak_i | ex_mem_id_excp_mret_i;
    // Earlier-stage exceptions take priority over any mem-stage fault.
    assign w_ld_mis   = w_is_load  & w_misal & ~w_up_excp;
    assign w_st_mis   = w_is_store & w_misal & ~w_up_excp;
    assign w_need_bus = (w_is_load | w_is_store) & ~w_misal & ~w_up_excp;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_kill;

    assign w_launch = (r_state == S_IDLE) && w_need_bus && !flush_i;

    // ---- latched bus operation, held for the whole access ----
    logic [XLEN-1:0]          r_op_addr;
    logic [2:0]               r_op_f3;
    logic                     r_op_we;
    logic [XLEN-1:0]          r_op_wdata;
    logic [3:0]               r_op_wstrb;
    logic [PC_WIDTH-1:0]      r_op_pc;
    logic [INSTR_WIDTH-1:0]   r_op_instr;
    logic [REG_IDX_WIDTH-1:0] r_op_rd_idx;
    logic                     r_op_rd_en;

    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_op_addr   <= w_addr;
            r_op_f3     <= w_f3;
            r_op_we     <= w_is_store;
            r_op_wdata  <= f_st_wdata(w_f3, ex_mem_rs2_rdata_i);
            r_op_wstrb  <= w_is_store ? f_st_wstrb(w_f3, w_addr[1:0]) : 4'b0000;
            r_op_pc     <= ex_mem_pc_i;
            r_op_instr  <= ex_mem_instr_i;
            r_op_rd_idx <= ex_mem_ex_rd_idx_i;
            r_op_rd_en  <= ex_mem_ex_rd_en_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WAIT && dbus_rsp_valid_i)
                r_kill <= 1'b0;
            else if ((r_state == S_REQ || r_state == S_WAIT) && flush_i)
                r_kill <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        dbus_req_valid_o = 1'b0;
        dbus_req_addr_o  = {r_op_addr[XLEN-1:2], 2'b00};
        dbus_req_we_o    = r_op_we;
        dbus_req_wdata_o = r_op_wdata;
        dbus_req_wstrb_o = r_op_wstrb;
        mem_stall_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    dbus_req_valid_o = 1'b1;
                    dbus_req_addr_o  = {w_addr[XLEN-1:2], 2'b00};
                    dbus_req_we_o    = w_is_store;
                    dbus_req_wdata_o = f_st_wdata(w_f3, ex_mem_rs2_rdata_i);
                    dbus_req_wstrb_o = w_is_store ? f_st_wstrb(w_f3, w_addr[1:0]) : 4'b0000;
                    mem_stall_o      = 1'b1;
                    w_state_nxt      = dbus_req_ready_i ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                dbus_req_valid_o = 1'b1;
                mem_stall_o      = 1'b1;
                if (dbus_req_ready_i)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mem_stall_o = ~dbus_rsp_valid_i;
                if (dbus_rsp_valid_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---- next mem_wb contents: bypass, completion, or bubble ----
    logic [PC_WIDTH-1:0]      w_wb_pc;
    logic [INSTR_WIDTH-1:0]   w_wb_instr;
    logic [REG_IDX_WIDTH-1:0] w_wb_rd_idx;
    logic                     w_wb_rd_en;
    logic [XLEN-1:0]          w_wb_rd_wdata;
    logic [5:0]               w_wb_up;
    logic                     w_wb_ld_mis;
    logic                     w_wb_st_mis;
    logic                     w_wb_ld_err;
    logic                     w_wb_st_err;
    logic [XLEN-1:0]          w_wb_excp_addr;

    always_comb begin
        w_wb_pc        = '0;
        w_wb_instr     = '0;
        w_wb_rd_idx    = '0;
        w_wb_rd_en     = 1'b0;
        w_wb_rd_wdata  = '0;
        w_wb_up        = '0;
        w_wb_ld_mis    = 1'b0;
        w_wb_st_mis    = 1'b0;
        w_wb_ld_err    = 1'b0;
        w_wb_st_err    = 1'b0;
        w_wb_excp_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (!flush_i && !w_need_bus) begin
                    w_wb_pc        = ex_mem_pc_i;
                    w_wb_instr     = ex_mem_instr_i;
                    w_wb_rd_idx    = ex_mem_ex_rd_idx_i;
                    w_wb_rd_en     = ex_mem_ex_rd_en_i & ~w_ld_mis;
                    w_wb_rd_wdata  = ex_mem_ex_rd_wdata_i;
                    w_wb_up        = {ex_mem_if_excp_misalign_i, ex_mem_if_bus_err_i,
                                      ex_mem_id_excp_ilegl_instr_i, ex_mem_id_excp_ecall_i,
                                      ex_mem_id_excp_ebreak_i, ex_mem_id_excp_mret_i};
                    w_wb_ld_mis    = w_ld_mis;
                    w_wb_st_mis    = w_st_mis;
                    w_wb_excp_addr = (w_ld_mis | w_st_mis) ? w_addr : '0;
                end
            end
            S_WAIT: begin
                if (dbus_rsp_valid_i && !r_kill && !flush_i) begin
                    w_wb_pc     = r_op_pc;
                    w_wb_instr  = r_op_instr;
                    w_wb_rd_idx = r_op_rd_idx;
                    if (dbus_rsp_err_i) begin
                        w_wb_ld_err    = ~r_op_we;
                        w_wb_st_err    = r_op_we;
                        w_wb_excp_addr = r_op_addr;
                    end else begin
                        w_wb_rd_en = r_op_rd_en;
                        if (!r_op_we)
                            w_wb_rd_wdata = f_load_fmt(r_op_f3, r_op_addr[1:0], dbus_rsp_rdata_i);
                    end
                end
            end
            default: ;
        endcase
    end

    // ---- mem_wb pipeline register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wb_pc_o                  <= '0;
            mem_wb_instr_o               <= '0;
            mem_wb_rd_idx_o              <= '0;
            mem_wb_rd_en_o               <= 1'b0;
            mem_wb_rd_wdata_o            <= '0;
            mem_wb_if_excp_misalign_o    <= 1'b0;
            mem_wb_if_bus_err_o          <= 1'b0;
            mem_wb_id_excp_ilegl_instr_o <= 1'b0;
            mem_wb_id_excp_ecall_o       <= 1'b0;
            mem_wb_id_excp_ebreak_o      <= 1'b0;
            mem_wb_id_excp_mret_o        <= 1'b0;
            mem_wb_excp_ld_misalign_o    <= 1'b0;
            mem_wb_excp_st_misalign_o    <= 1'b0;
            mem_wb_excp_ld_bus_err_o     <= 1'b0;
            mem_wb_excp_st_bus_err_o     <= 1'b0;
            mem_wb_excp_addr_o           <= '0;
        end else begin
            mem_wb_pc_o                  <= w_wb_pc;
            mem_wb_instr_o               <= w_wb_instr;
            mem_wb_rd_idx_o              <= w_wb_rd_idx;
            mem_wb_rd_en_o               <= w_wb_rd_en;
            mem_wb_rd_wdata_o            <= w_wb_rd_wdata;
            mem_wb_if_excp_misalign_o    <= w_wb_up[5];
            mem_wb_if_bus_err_o          <= w_wb_up[4];
            mem_wb_id_excp_ilegl_instr_o <= w_wb_up[3];
            mem_wb_id_excp_ecall_o       <= w_wb_up[2];
            mem_wb_id_excp_ebreak_o      <= w_wb_up[1];
            mem_wb_id_excp_mret_o        <= w_wb_up[0];
            mem_wb_excp_ld_misalign_o    <= w_wb_ld_mis;
            mem_wb_excp_st_misalign_o    <= w_wb_st_mis;
            mem_wb_excp_ld_bus_err_o     <= w_wb_ld_err;
            mem_wb_excp_st_bus_err_o     <= w_wb_st_err;
            mem_wb_excp_addr_o           <= w_wb_excp_addr;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, bus errors,
// upstream exception pass-through, flush and reset during an access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_mem_pc_i, ex_mem_instr_i, ex_mem_rs2_rdata_i, ex_mem_alu_res_i;
    logic [4:0]  ex_mem_ex_rd_idx_i;
    logic        ex_mem_ex_rd_en_i;
    logic [31:0] ex_mem_ex_rd_wdata_i;
    logic        ex_mem_if_excp_misalign_i, ex_mem_if_bus_err_i, ex_mem_id_excp_ilegl_instr_i;
    logic        ex_mem_id_excp_ecall_i, ex_mem_id_excp_ebreak_i, ex_mem_id_excp_mret_i;
    logic        flush_i;
    logic        dbus_req_valid_o, dbus_req_ready_i, dbus_req_we_o;
    logic [31:0] dbus_req_addr_o, dbus_req_wdata_o;
    logic [3:0]  dbus_req_wstrb_o;
    logic        dbus_rsp_valid_i, dbus_rsp_err_i;
    logic [31:0] dbus_rsp_rdata_i;
    logic        mem_stall_o;
    logic [31:0] mem_wb_pc_o, mem_wb_instr_o, mem_wb_rd_wdata_o, mem_wb_excp_addr_o;
    logic [4:0]  mem_wb_rd_idx_o;
    logic        mem_wb_rd_en_o;
    logic        mem_wb_if_excp_misalign_o, mem_wb_if_bus_err_o, mem_wb_id_excp_ilegl_instr_o;
    logic        mem_wb_id_excp_ecall_o, mem_wb_id_excp_ebreak_o, mem_wb_id_excp_mret_o;
    logic        mem_wb_excp_ld_misalign_o, mem_wb_excp_st_misalign_o;
    logic        mem_wb_excp_ld_bus_err_o, mem_wb_excp_st_bus_err_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_pc_i(ex_mem_pc_i), .ex_mem_instr_i(ex_mem_instr_i),
        .ex_mem_rs2_rdata_i(ex_mem_rs2_rdata_i), .ex_mem_alu_res_i(ex_mem_alu_res_i),
        .ex_mem_ex_rd_idx_i(ex_mem_ex_rd_idx_i), .ex_mem_ex_rd_en_i(ex_mem_ex_rd_en_i),
        .ex_mem_ex_rd_wdata_i(ex_mem_ex_rd_wdata_i),
        .ex_mem_if_excp_misalign_i(ex_mem_if_excp_misalign_i),
        .ex_mem_if_bus_err_i(ex_mem_if_bus_err_i),
        .ex_mem_id_excp_ilegl_instr_i(ex_mem_id_excp_ilegl_instr_i),
        .ex_mem_id_excp_ecall_i(ex_mem_id_excp_ecall_i),
        .ex_mem_id_excp_ebreak_i(ex_mem_id_excp_ebreak_i),
        .ex_mem_id_excp_mret_i(ex_mem_id_excp_mret_i),
        .flush_i(flush_i),
        .dbus_req_valid_o(dbus_req_valid_o), .dbus_req_ready_i(dbus_req_ready_i),
        .dbus_req_addr_o(dbus_req_addr_o), .dbus_req_we_o(dbus_req_we_o),
        .dbus_req_wdata_o(dbus_req_wdata_o), .dbus_req_wstrb_o(dbus_req_wstrb_o),
        .dbus_rsp_valid_i(dbus_rsp_valid_i), .dbus_rsp_rdata_i(dbus_rsp_rdata_i),
        .dbus_rsp_err_i(dbus_rsp_err_i),
        .mem_stall_o(mem_stall_o),
        .mem_wb_pc_o(mem_wb_pc_o), .mem_wb_instr_o(mem_wb_instr_o),
        .mem_wb_rd_idx_o(mem_wb_rd_idx_o), .mem_wb_rd_en_o(mem_wb_rd_en_o),
        .mem_wb_rd_wdata_o(mem_wb_rd_wdata_o),
        .mem_wb_if_excp_misalign_o(mem_wb_if_excp_misalign_o),
        .mem_wb_if_bus_err_o(mem_wb_if_bus_err_o),
        .mem_wb_id_excp_ilegl_instr_o(mem_wb_id_excp_ilegl_instr_o),
        .mem_wb_id_excp_ecall_o(mem_wb_id_excp_ecall_o),
        .mem_wb_id_excp_ebreak_o(mem_wb_id_excp_ebreak_o),
        .mem_wb_id_excp_mret_o(mem_wb_id_excp_mret_o),
        .mem_wb_excp_ld_misalign_o(mem_wb_excp_ld_misalign_o),
        .mem_wb_excp_st_misalign_o(mem_wb_excp_st_misalign_o),
        .mem_wb_excp_ld_bus_err_o(mem_wb_excp_ld_bus_err_o),
        .mem_wb_excp_st_bus_err_o(mem_wb_excp_st_bus_err_o),
        .mem_wb_excp_addr_o(mem_wb_excp_addr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'b0, f3, 5'b0, op};
    endfunction

    task automatic nop_inputs();
        ex_mem_pc_i = '0; ex_mem_instr_i = '0; ex_mem_rs2_rdata_i = '0; ex_mem_alu_res_i = '0;
        ex_mem_ex_rd_idx_i = '0; ex_mem_ex_rd_en_i = 1'b0; ex_mem_ex_rd_wdata_i = '0;
        ex_mem_if_excp_misalign_i = 1'b0; ex_mem_if_bus_err_i = 1'b0;
        ex_mem_id_excp_ilegl_instr_i = 1'b0; ex_mem_id_excp_ecall_i = 1'b0;
        ex_mem_id_excp_ebreak_i = 1'b0; ex_mem_id_excp_mret_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one bus access from launch to response; the completion edge has
    // passed on return and ex_mem inputs are back to a non-memory bubble.
    task automatic mem_access(input string nm, input logic [31:0] instr, input logic [31:0] addr,
                              input logic [31:0] rs2, input int ready_lat,
                              input logic [31:0] rdata, input logic err, input logic flush_wait,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [3:0] e_wstrb, input logic e_we);
        ex_mem_pc_i = 32'h0000_0400; ex_mem_instr_i = instr; ex_mem_alu_res_i = addr;
        ex_mem_rs2_rdata_i = rs2; ex_mem_ex_rd_idx_i = 5'd7; ex_mem_ex_rd_en_i = ~instr[5];
        dbus_req_ready_i = (ready_lat == 0);
        #4;
        chk({nm, " launch valid"}, dbus_req_valid_o, 1'b1);
        chk({nm, " launch stall"}, mem_stall_o, 1'b1);
        chk({nm, " launch addr"}, dbus_req_addr_o, e_addr);
        chk({nm, " launch wstrb"}, dbus_req_wstrb_o, e_wstrb);
        chk({nm, " launch wdata"}, dbus_req_wdata_o, e_wdata);
        chk({nm, " launch we"}, dbus_req_we_o, e_we);
        for (int i = 0; i < ready_lat; i++) begin
            tick();
            dbus_req_ready_i = (i == ready_lat - 1);
            #4;
            chk({nm, " req valid"}, dbus_req_valid_o, 1'b1);
            chk({nm, " req addr"}, dbus_req_addr_o, e_addr);
            chk({nm, " req wstrb"}, dbus_req_wstrb_o, e_wstrb);
            chk({nm, " req wdata"}, dbus_req_wdata_o, e_wdata);
            chk({nm, " req we"}, dbus_req_we_o, e_we);
            chk({nm, " req bubble"}, mem_wb_rd_en_o, 1'b0);
        end
        tick();
        dbus_req_ready_i = 1'b0;
        flush_i = flush_wait;
        #4;
        chk({nm, " wait stall"}, mem_stall_o, 1'b1);
        chk({nm, " wait valid"}, dbus_req_valid_o, 1'b0);
        chk({nm, " wait bubble"}, mem_wb_pc_o, 32'h0);
        tick();
        flush_i = 1'b0;
        dbus_rsp_valid_i = 1'b1; dbus_rsp_rdata_i = rdata; dbus_rsp_err_i = err;
        #4;
        chk({nm, " rsp stall"}, mem_stall_o, 1'b0);
        tick();
        dbus_rsp_valid_i = 1'b0; dbus_rsp_err_i = 1'b0; dbus_rsp_rdata_i = '0;
        nop_inputs();
    endtask

    initial begin
        nop_inputs();
        dbus_req_ready_i = 1'b0; dbus_rsp_valid_i = 1'b0; dbus_rsp_err_i = 1'b0;
        dbus_rsp_rdata_i = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #4;
        chk("rst rd_en", mem_wb_rd_en_o, 1'b0);
        chk("rst excp_addr", mem_wb_excp_addr_o, 32'h0);
        chk("rst req_valid", dbus_req_valid_o, 1'b0);
        chk("rst stall", mem_stall_o, 1'b0);
        tick();

        // Reset asserted while an LW waits for its response.
        ex_mem_instr_i = mk(3'b010, 7'b0000011); ex_mem_alu_res_i = 32'h100;
        ex_mem_ex_rd_en_i = 1'b1; ex_mem_ex_rd_idx_i = 5'd3; ex_mem_pc_i = 32'h80;
        dbus_req_ready_i = 1'b1;
        tick();
        dbus_req_ready_i = 1'b0;
        nop_inputs();
        rst_n = 1'b0;
        tick(); tick();
        chk("midrst pc", mem_wb_pc_o, 32'h0);
        chk("midrst rd_en", mem_wb_rd_en_o, 1'b0);
        chk("midrst req_valid", dbus_req_valid_o, 1'b0);
        rst_n = 1'b1;
        dbus_rsp_valid_i = 1'b1; dbus_rsp_rdata_i = 32'hFFFF_FFFF;
        #4;
        chk("late rsp stall", mem_stall_o, 1'b0);
        tick();
        dbus_rsp_valid_i = 1'b0; dbus_rsp_rdata_i = '0;
        chk("late rsp rd_en", mem_wb_rd_en_o, 1'b0);
        chk("late rsp wdata", mem_wb_rd_wdata_o, 32'h0);

        mem_access("LB", mk(3'b000, 7'b0000011), 32'h1003, 32'h0, 0, 32'h80AA_5511, 1'b0, 1'b0,
                   32'h1000, 32'h0, 4'b0000, 1'b0);
        chk("LB wdata", mem_wb_rd_wdata_o, 32'hFFFF_FF80);
        chk("LB rd_en", mem_wb_rd_en_o, 1'b1);
        chk("LB rd_idx", mem_wb_rd_idx_o, 32'd7);
        chk("LB pc", mem_wb_pc_o, 32'h400);

        mem_access("LBU", mk(3'b100, 7'b0000011), 32'h1003, 32'h0, 0, 32'h80AA_5511, 1'b0, 1'b0,
                   32'h1000, 32'h0, 4'b0000, 1'b0);
        chk("LBU wdata", mem_wb_rd_wdata_o, 32'h0000_0080);

        mem_access("LH", mk(3'b001, 7'b0000011), 32'h7002, 32'h0, 0, 32'h8001_0000, 1'b0, 1'b0,
                   32'h7000, 32'h0, 4'b0000, 1'b0);
        chk("LH wdata", mem_wb_rd_wdata_o, 32'hFFFF_8001);

        mem_access("LHU", mk(3'b101, 7'b0000011), 32'h7000, 32'h0, 0, 32'h8001_F00F, 1'b0, 1'b0,
                   32'h7000, 32'h0, 4'b0000, 1'b0);
        chk("LHU wdata", mem_wb_rd_wdata_o, 32'h0000_F00F);

        mem_access("SH", mk(3'b001, 7'b0100011), 32'h2002, 32'h1234_ABCD, 3, 32'h0, 1'b0, 1'b0,
                   32'h2000, 32'hABCD_ABCD, 4'b1100, 1'b1);
        chk("SH rd_en", mem_wb_rd_en_o, 1'b0);
        chk("SH st_err", mem_wb_excp_st_bus_err_o, 1'b0);
        chk("SH pc", mem_wb_pc_o, 32'h400);

        mem_access("SB", mk(3'b000, 7'b0100011), 32'h2001, 32'h0000_00EE, 0, 32'h0, 1'b0, 1'b0,
                   32'h2000, 32'hEEEE_EEEE, 4'b0010, 1'b1);

        // Misaligned LW bypasses the bus, then an ADD flows straight through.
        ex_mem_instr_i = mk(3'b010, 7'b0000011); ex_mem_alu_res_i = 32'h3001;
        ex_mem_ex_rd_en_i = 1'b1; ex_mem_pc_i = 32'h500;
        #4;
        chk("LWmis req_valid", dbus_req_valid_o, 1'b0);
        chk("LWmis stall", mem_stall_o, 1'b0);
        tick();
        chk("LWmis ld_misalign", mem_wb_excp_ld_misalign_o, 1'b1);
        chk("LWmis excp_addr", mem_wb_excp_addr_o, 32'h3001);
        chk("LWmis rd_en", mem_wb_rd_en_o, 1'b0);
        ex_mem_instr_i = mk(3'b000, 7'b0110011); ex_mem_alu_res_i = 32'h5;
        ex_mem_ex_rd_wdata_i = 32'h5; ex_mem_ex_rd_en_i = 1'b1; ex_mem_pc_i = 32'h504;
        tick();
        chk("ADD wdata", mem_wb_rd_wdata_o, 32'h5);
        chk("ADD rd_en", mem_wb_rd_en_o, 1'b1);
        chk("ADD ld_misalign", mem_wb_excp_ld_misalign_o, 1'b0);
        chk("ADD excp_addr", mem_wb_excp_addr_o, 32'h0);
        nop_inputs();

        mem_access("LWerr", mk(3'b010, 7'b0000011), 32'h4000, 32'h0, 0, 32'h1111_2222, 1'b1, 1'b0,
                   32'h4000, 32'h0, 4'b0000, 1'b0);
        chk("LWerr ld_bus_err", mem_wb_excp_ld_bus_err_o, 1'b1);
        chk("LWerr rd_en", mem_wb_rd_en_o, 1'b0);
        chk("LWerr excp_addr", mem_wb_excp_addr_o, 32'h4000);

        // Store carrying an ecall flag never reaches the bus.
        ex_mem_instr_i = mk(3'b010, 7'b0100011); ex_mem_alu_res_i = 32'h5000;
        ex_mem_id_excp_ecall_i = 1'b1; ex_mem_pc_i = 32'h600;
        #4;
        chk("ecall req_valid", dbus_req_valid_o, 1'b0);
        chk("ecall stall", mem_stall_o, 1'b0);
        tick();
        chk("ecall flag", mem_wb_id_excp_ecall_o, 1'b1);
        chk("ecall pc", mem_wb_pc_o, 32'h600);
        chk("ecall st_misalign", mem_wb_excp_st_misalign_o, 1'b0);
        nop_inputs();
        tick();

        mem_access("LWflush", mk(3'b010, 7'b0000011), 32'h6000, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b1,
                   32'h6000, 32'h0, 4'b0000, 1'b0);
        chk("flush rd_en", mem_wb_rd_en_o, 1'b0);
        chk("flush wdata", mem_wb_rd_wdata_o, 32'h0);
        chk("flush pc", mem_wb_pc_o, 32'h0);
        chk("flush ld_err", mem_wb_excp_ld_bus_err_o, 1'b0);

        mem_access("LWnext", mk(3'b010, 7'b0000011), 32'h6004, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0,
                   32'h6004, 32'h0, 4'b0000, 1'b0);
        chk("LWnext wdata", mem_wb_rd_wdata_o, 32'hCAFE_F00D);
        chk("LWnext rd_en", mem_wb_rd_en_o, 1'b1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of ex_mem. Consumes the ex_mem outputs and performs RV32I loads and stores over a valid/ready data bus.
- Formats load data, detects load/store misalignment and bus errors, and stalls upstream while an access is outstanding.
- Registers the result into the mem_wb pipeline outputs consumed by writeback and the trap unit.

Parameters:
XLEN, 32, data/address width
PC_WIDTH, 32, pc width
INSTR_WIDTH, 32, instruction width
REG_IDX_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ex_mem_pc_i  in  PC_WIDTH  pc of instruction in stage
ex_mem_instr_i  in  INSTR_WIDTH  instruction; opcode[6:0], funct3[14:12]
ex_mem_rs2_rdata_i  in  XLEN  store data
ex_mem_alu_res_i  in  XLEN  effective address
ex_mem_ex_rd_idx_i  in  REG_IDX_WIDTH  destination register
ex_mem_ex_rd_en_i  in  1  destination write enable
ex_mem_ex_rd_wdata_i  in  XLEN  non-load writeback data
ex_mem_{if_excp_misalign,if_bus_err,id_excp_ilegl_instr,id_excp_ecall,id_excp_ebreak,id_excp_mret}_i  in  1 each  upstream exception flags
flush_i  in  1  trap-unit kill of the instruction in this stage
dbus_req_valid_o  out  1  request valid
dbus_req_ready_i  in  1  request accepted
dbus_req_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dbus_req_we_o  out  1  1 = store
dbus_req_wdata_o  out  XLEN  lane-replicated store data
dbus_req_wstrb_o  out  4  byte strobes (0 for loads)
dbus_rsp_valid_i  in  1  response valid
dbus_rsp_rdata_i  in  XLEN  load data, full word
dbus_rsp_err_i  in  1  bus error, qualified by rsp_valid
mem_stall_o  out  1  upstream (ex_mem and earlier) must hold
mem_wb_pc_o, mem_wb_instr_o  out  PC_WIDTH/INSTR_WIDTH  registered
mem_wb_rd_idx_o, mem_wb_rd_en_o, mem_wb_rd_wdata_o  out  REG_IDX_WIDTH/1/XLEN  registered writeback
mem_wb_{six upstream flags}_o  out  1 each  registered pass-through
mem_wb_excp_{ld_misalign,st_misalign,ld_bus_err,st_bus_err}_o  out  1 each  registered mem-stage exceptions
mem_wb_excp_addr_o  out  XLEN  faulting byte address, 0 if none

Behaviour:
- Clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset: FSM=IDLE; kill=0; every mem_wb_* output=0. dbus_req_valid_o=0 and mem_stall_o=0, because instr=0 is not a memory op.
- Decode:
  - Load: opcode 0000011; funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: opcode 0100011; funct3 000 SB, 001 SH, 010 SW.
  - Other funct3 values: treated as non-memory; ID has already flagged them illegal.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0 → no bus request; set ld_/st_misalign and excp_addr=addr.
- Bypass case: any upstream flag set, misaligned access, or non-memory instr. No bus request; result registered at the next edge (1-cycle latency); rd_wdata=ex_rd_wdata_i. A misaligned load forces rd_en=0.
- FSM states IDLE, REQ, WAIT:
  - IDLE with a bus-needing op and flush_i=0: latch op (addr, funct3, we, wdata, wstrb, pc, instr, rd_idx, flags) and assert dbus_req_valid_o combinationally. ready=1 → WAIT; ready=0 → REQ.
  - REQ: drive request from latched op; valid is never withdrawn, flush does not cancel it. ready → WAIT.
  - WAIT: on rsp_valid → IDLE.
  - A response is only recognised in WAIT. The bus guarantees ≥1 cycle between acceptance and response.
- Stall: mem_stall_o=1 from the IDLE launch cycle through REQ/WAIT, deasserted in the rsp_valid cycle. mem_wb loads a bubble (all 0) on every stalled edge.
- Completion: at the rsp_valid edge, mem_wb captures the latched op.
  - Load: rd_wdata = formatted rdata. Byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend.
  - rsp_err → ld_/st_bus_err=1, rd_en=0, excp_addr=addr.
- Store encoding:
  - SB: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: wstrb=1111, wdata=rs2.
- flush_i:
  - In IDLE: suppresses the request; mem_wb loads a bubble.
  - In REQ/WAIT: sets kill. The FSM completes the handshake, the response is discarded (bubble written) and kill clears on return to IDLE. mem_stall_o stays high until then.
- Minimum load latency: launch cycle t (ready=1), rsp at t+1, mem_wb valid after edge t+1.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-WAIT → all mem_wb_*=0, dbus_req_valid_o=0, state IDLE; a late rsp_valid is ignored.
- LB at addr 0x1003, rdata 0x80AA_5511, ready=1, rsp one cycle later → mem_wb_rd_wdata=0xFFFFFF80, rd_en=1, stall high 2 cycles. LBU at the same address → 0x00000080.
- SH at addr 0x2002, rs2=0x1234ABCD → req addr 0x2000, wstrb=1100, wdata=0xABCDABCD, we=1; ready held low 3 cycles → valid and all fields stable throughout.
- LW at 0x3001 → no dbus_req_valid, ld_misalign=1, excp_addr=0x3001, rd_en=0, no stall. ADD (opcode 0110011) with rd_wdata=5 → mem_wb_rd_wdata=5 one cycle later.
- LW at 0x4000 with rsp_err=1 → ld_bus_err=1, rd_en=0, excp_addr=0x4000. Ecall flag set on a store → no bus request, ecall flag passed through.
- flush_i during WAIT of LW → stall held until rsp, mem_wb gets a bubble (rd_en=0, no flags), next instruction proceeds normally.
